// File: rtl/csa32_mux_adder.sv
// ============================================================================
//  Module   : csa32_mux_adder
//  Purpose  : 32-bit carry-select adder with a 2:1 B-operand mux and a
//             one-stage registered result with valid flag.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module csa32_mux_adder #(
  parameter int BLOCK_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b0,
  input  logic [31:0] b1,
  input  logic        sel,
  input  logic        cin,
  input  logic        in_valid,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf,
  output logic [31:0] sum_q,
  output logic        cout_q,
  output logic        ovf_q,
  output logic        out_valid
);

  localparam int NBLK = 32 / BLOCK_W;

  // Bit-serial ripple add of one block; returns {carry_out, sum}.
  function automatic logic [BLOCK_W:0] f_ripple(
    input logic [BLOCK_W-1:0] x,
    input logic [BLOCK_W-1:0] y,
    input logic               ci
  );
    logic [BLOCK_W-1:0] s;
    logic               c;
    c = ci;
    for (int j = 0; j < BLOCK_W; j++) begin
      s[j] = x[j] ^ y[j] ^ c;
      c    = (x[j] & y[j]) | (x[j] & c) | (y[j] & c);
    end
    return {c, s};
  endfunction

  logic [31:0]   w_bsel;
  logic [31:0]   w_sum;
  logic [NBLK:0] w_bc;
  logic          w_c31;

  logic [31:0]   r_sum;
  logic          r_cout;
  logic          r_ovf;
  logic          r_valid;

  assign w_bsel  = sel ? b1 : b0;
  assign w_bc[0] = cin;

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    if (i == 0) begin : g_ripple
      logic [BLOCK_W:0] w_r;
      assign w_r = f_ripple(a[BLOCK_W-1:0], w_bsel[BLOCK_W-1:0], w_bc[0]);
      assign w_sum[BLOCK_W-1:0] = w_r[BLOCK_W-1:0];
      assign w_bc[1]            = w_r[BLOCK_W];
    end else begin : g_select
      logic [BLOCK_W:0] w_r0;
      logic [BLOCK_W:0] w_r1;
      assign w_r0 = f_ripple(a[i*BLOCK_W +: BLOCK_W], w_bsel[i*BLOCK_W +: BLOCK_W], 1'b0);
      assign w_r1 = f_ripple(a[i*BLOCK_W +: BLOCK_W], w_bsel[i*BLOCK_W +: BLOCK_W], 1'b1);
      assign w_sum[i*BLOCK_W +: BLOCK_W] = w_bc[i] ? w_r1[BLOCK_W-1:0] : w_r0[BLOCK_W-1:0];
      assign w_bc[i+1]                   = w_bc[i] ? w_r1[BLOCK_W]     : w_r0[BLOCK_W];
    end
  end

  // Carry into bit 31 recovered from the sum bit itself.
  assign w_c31 = a[31] ^ w_bsel[31] ^ w_sum[31];

  assign sum  = w_sum;
  assign cout = w_bc[NBLK];
  assign ovf  = w_c31 ^ w_bc[NBLK];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_bc[NBLK];
        r_ovf  <= w_c31 ^ w_bc[NBLK];
      end
    end
  end

  assign sum_q     = r_sum;
  assign cout_q    = r_cout;
  assign ovf_q     = r_ovf;
  assign out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_csa32_mux_adder.sv
// ============================================================================
//  Module   : tb_csa32_mux_adder
//  Purpose  : Self-checking bench; one DUT per block width, shared stimulus.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_csa32_mux_adder;

  localparam int NDUT = 4;

  logic        clk      = 1'b0;
  logic        rst;
  logic [31:0] a        = '0;
  logic [31:0] b0       = '0;
  logic [31:0] b1       = '0;
  logic        sel      = 1'b0;
  logic        cin      = 1'b0;
  logic        in_valid = 1'b0;

  logic [31:0] sum_o   [NDUT];
  logic        cout_o  [NDUT];
  logic        ovf_o   [NDUT];
  logic [31:0] sumq_o  [NDUT];
  logic        coutq_o [NDUT];
  logic        ovfq_o  [NDUT];
  logic        vld_o   [NDUT];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    csa32_mux_adder #(.BLOCK_W(2 << k)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b0        (b0),
      .b1        (b1),
      .sel       (sel),
      .cin       (cin),
      .in_valid  (in_valid),
      .sum       (sum_o[k]),
      .cout      (cout_o[k]),
      .ovf       (ovf_o[k]),
      .sum_q     (sumq_o[k]),
      .cout_q    (coutq_o[k]),
      .ovf_q     (ovfq_o[k]),
      .out_valid (vld_o[k])
    );
  end

  // Reference: plain 33-bit add; returns {ovf, cout, sum}.
  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci);
    logic [32:0] t;
    logic        v;
    t = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    v = (x[31] == y[31]) && (t[31] != x[31]);
    return {v, t[32], t[31:0]};
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s bw=%0d actual=%h required=%h t=%0t", nm, 2 << k, act, exp, $time);
    end
  endtask

  // Model of the registered stage.
  logic [31:0] m_sum  = '0;
  logic        m_cout = 1'b0;
  logic        m_ovf  = 1'b0;
  logic        m_vld  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
      m_vld  <= 1'b0;
    end else begin
      m_vld <= in_valid;
      if (in_valid) {m_ovf, m_cout, m_sum} <= ref_add(a, sel ? b1 : b0, cin);
    end
  end

  // Compare process: every cycle, shortly after the rising edge.
  always @(posedge clk) begin
    logic [33:0] e;
    #1;
    e = ref_add(a, sel ? b1 : b0, cin);
    for (int k = 0; k < NDUT; k++) begin
      chk("sum",       k, sum_o[k],          e[31:0]);
      chk("cout",      k, {31'd0, cout_o[k]}, {31'd0, e[32]});
      chk("ovf",       k, {31'd0, ovf_o[k]},  {31'd0, e[33]});
      chk("sum_q",     k, sumq_o[k],         m_sum);
      chk("cout_q",    k, {31'd0, coutq_o[k]}, {31'd0, m_cout});
      chk("ovf_q",     k, {31'd0, ovfq_o[k]},  {31'd0, m_ovf});
      chk("out_valid", k, {31'd0, vld_o[k]},   {31'd0, m_vld});
    end
  end

  task automatic drive(input logic [31:0] ta, input logic [31:0] tb0, input logic [31:0] tb1,
                       input logic ts, input logic tc, input logic tv);
    @(negedge clk);
    a = ta; b0 = tb0; b1 = tb1; sel = ts; cin = tc; in_valid = tv;
  endtask

  task automatic exp_comb(input string nm, input logic [31:0] es, input logic ec,
                          input logic eo);
    #2;
    for (int k = 0; k < NDUT; k++) begin
      chk({nm, ".sum"},  k, sum_o[k],           es);
      chk({nm, ".cout"}, k, {31'd0, cout_o[k]}, {31'd0, ec});
      chk({nm, ".ovf"},  k, {31'd0, ovf_o[k]},  {31'd0, eo});
    end
  endtask

  task automatic exp_reg(input string nm, input logic [31:0] es, input logic ev);
    for (int k = 0; k < NDUT; k++) begin
      chk({nm, ".sum_q"},     k, sumq_o[k],         es);
      chk({nm, ".out_valid"}, k, {31'd0, vld_o[k]}, {31'd0, ev});
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    exp_reg("reset", 32'h0, 1'b0);
    for (int k = 0; k < NDUT; k++) begin
      chk("reset.cout_q", k, {31'd0, coutq_o[k]}, 32'd0);
      chk("reset.ovf_q",  k, {31'd0, ovfq_o[k]},  32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    drive(32'h0000003C, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1);
    exp_comb("basic", 32'h0000003D, 1'b0, 1'b0);
    drive(32'hFFFFFFFF, 32'h12345678, 32'h1, 1'b1, 1'b0, 1'b1);
    exp_reg("basic", 32'h0000003D, 1'b1);
    exp_comb("wrap", 32'h0, 1'b1, 1'b0);
    drive(32'hFFFFFFFF, 32'h12345678, 32'h1, 1'b0, 1'b0, 1'b1);
    exp_comb("selflip", 32'h12345677, 1'b1, 1'b0);
    drive(32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1);
    exp_comb("posovf", 32'h80000000, 1'b0, 1'b1);
    drive(32'h80000000, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b1);
    exp_comb("negovf", 32'h0, 1'b1, 1'b1);
    drive(32'h0000000F, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1);
    exp_comb("blk0", 32'h00000010, 1'b0, 1'b0);
    drive(32'h0FFFFFFF, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    exp_comb("chain", 32'h10000000, 1'b0, 1'b0);
    drive(32'h5, ~32'h3, 32'h0, 1'b0, 1'b1, 1'b1);
    exp_comb("sub5m3", 32'h2, 1'b1, 1'b0);
    drive(32'h3, ~32'h5, 32'h0, 1'b0, 1'b1, 1'b1);
    exp_comb("sub3m5", 32'hFFFFFFFE, 1'b0, 1'b0);

    // Pipeline: 1+2, 3+4, 5+6 back-to-back, then two idle cycles.
    drive(32'd1, 32'd2, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(32'd3, 32'd4, 32'h0, 1'b0, 1'b0, 1'b1);
    #2 exp_reg("pipe0", 32'd3, 1'b1);
    drive(32'd5, 32'd6, 32'h0, 1'b0, 1'b0, 1'b1);
    #2 exp_reg("pipe1", 32'd7, 1'b1);
    drive(32'd9, 32'd9, 32'h0, 1'b0, 1'b0, 1'b0);
    #2 exp_reg("pipe2", 32'd11, 1'b1);
    drive(32'd8, 32'd8, 32'h0, 1'b0, 1'b0, 1'b0);
    #2 exp_reg("hold0", 32'd11, 1'b0);
    @(negedge clk);
    #2 exp_reg("hold1", 32'd11, 1'b0);

    // Asynchronous reset mid-stream.
    drive(32'd10, 32'd20, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(32'd40, 32'd2, 32'h0, 1'b0, 1'b0, 1'b1);
    #2 exp_reg("prerst", 32'd30, 1'b1);
    #1 rst = 1'b1;
    #1 exp_reg("asyncrst", 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(32'd100, 32'd23, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(32'd0, 32'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2 exp_reg("postrst", 32'd123, 1'b1);

    // Random sweep; the compare process checks every cycle.
    for (int n = 0; n < 10000; n++) begin
      drive($urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0));
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/csa32_mux_adder.md
Name: csa32_mux_adder

Overview:
- 32-bit carry-select adder with a 2:1 32-bit operand mux on the B input and a one-stage output register.
- Used for byte-address generation, e.g. base+1/+2/+3 for big-endian word access into byte-wide memories, and for general add with carry/overflow flags.
- Provides a combinational result path and a registered result path with a valid flag.

Parameters:
- BLOCK_W, 4, carry-select block width in bits; must divide 32 (legal: 2, 4, 8, 16).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- a  input  32  operand A
- b0  input  32  operand B candidate 0
- b1  input  32  operand B candidate 1
- sel  input  1  mux select; 0 -> b0, 1 -> b1
- cin  input  1  carry in
- in_valid  input  1  qualifies a/b0/b1/sel/cin for registering
- sum  output  32  combinational a + bsel + cin (low 32 bits)
- cout  output  1  combinational carry out of bit 31
- ovf  output  1  combinational signed overflow
- sum_q  output  32  registered sum
- cout_q  output  1  registered cout
- ovf_q  output  1  registered ovf
- out_valid  output  1  registered in_valid

Behaviour:
- Mux: bsel = sel ? b1 : b0. Purely combinational, 32 bits wide, no X-propagation tricks.
- Adder structure: split into 32/BLOCK_W blocks.
  - Block 0 is a ripple adder driven by cin.
  - Every other block computes two ripple sums in parallel, one with carry-in 0 and one with carry-in 1.
  - The incoming block carry selects the sum bits and the block carry out.
- Result: sum = (a + bsel + cin) mod 2^32.
  - cout = bit 32 of the full 33-bit sum.
  - ovf = carry into bit 31 XOR cout, which equals (a[31]==bsel[31]) && (sum[31]!=a[31]).
- Combinational outputs have zero latency and follow the inputs in the same cycle.
- Register stage updates on the rising clk edge:
  - out_valid <= in_valid every cycle.
  - sum_q/cout_q/ovf_q load sum/cout/ovf only when in_valid=1; otherwise they hold.
- Registered latency is exactly 1 cycle from in_valid=1 to out_valid=1 with the matching result.
- Back-to-back in_valid produces one result per cycle. There is no stall or backpressure.
- Reset: while rst=1, sum_q=0, cout_q=0, ovf_q=0, out_valid=0, regardless of clk.
  - Asserting rst mid-stream discards the in-flight result.
  - The first in_valid sampled after rst deasserts yields out_valid one cycle later.
- Boundary cases:
  - Wrap-around: 0xFFFFFFFF + 1 yields sum 0, cout 1, ovf 0.
  - Subtraction-style use (b = ~x, cin=1): it is legal, and cout follows unsigned add semantics (no borrow inversion).
- The sel change and the operand change in the same cycle are both sampled together. No ordering dependence.

Test Plan:
- a=0x0000003C, b0=0x00000001, sel=0, cin=0, in_valid=1 -> sum=0x0000003D, cout=0, ovf=0 combinationally. Next edge: sum_q=0x0000003D, out_valid=1.
- a=0xFFFFFFFF, b1=0x00000001, b0=0x12345678, sel=1, cin=0 -> sum=0x00000000, cout=1, ovf=0. Then flip sel=0 -> sum=0x12345677, cout=1, ovf=0.
- a=0x7FFFFFFF, b0=0x00000001, sel=0, cin=0 -> sum=0x80000000, cout=0, ovf=1. Then a=0x80000000, b0=0x80000000 -> sum=0, cout=1, ovf=1.
- Carry-select boundaries:
  - a=0x0000000F, b0=1 -> 0x00000010 (block-0 carry crossing).
  - a=0x0FFFFFFF, b0=0, cin=1 -> 0x10000000 (carry chain through all selects).
  - Repeat with BLOCK_W=2, 8, 16.
- Pipeline/valid:
  - Apply 3 consecutive valid inputs (1+2, 3+4, 5+6), then in_valid=0 for 2 cycles -> sum_q sequence 3, 7, 11, then holds 11 with out_valid=0.
  - Assert rst asynchronously mid-sequence -> all registered outputs 0 immediately.
- Random: 10k random a/b0/b1/sel/cin compared against a 33-bit reference add, for both combinational and 1-cycle-delayed registered outputs.
